key_debouncer: RTL and testbench

- Conditions one raw push-button (DE-board KEY, mechanically bouncy, active-low) into clean signals for the system.
- btn_level drives pio_bouton_external_connection_export, so the PIO edge-capture/IRQ sees exactly one edge per physical press.
- press_pulse, release_pulse, long_press_pulse and press_count are exported for fabric logic and debug.

---
 rtl/key_debouncer.sv | 120 ++++++++++++
 tb/tb_key_debouncer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - Push-button synchronizer and debouncer with press/release/long-press strobes.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  localparam logic          IDLE     = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          s;
  logic          long_done;
  logic          releasing;
  logic          holding;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;

  assign s         = sync2 ^ IDLE;
  assign holding   = (state == PRESSED) || (state == WAIT_RELEASE);
  // The release edge suppresses a coincident long-press strobe so strobes stay mutually exclusive.
  assign releasing = (state == WAIT_RELEASE) && !s && (deb_cnt == DEB_MAX);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state            <= RELEASED;
      sync1            <= IDLE;
      sync2            <= IDLE;
      deb_cnt          <= '0;
      hold_cnt         <= '0;
      long_done        <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      press_count      <= 8'd0;
    end else begin
      sync1            <= btn_raw;
      sync2            <= sync1;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;

      case (state)
        RELEASED: begin
          if (s) begin
            state   <= WAIT_PRESS;
            deb_cnt <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!s) begin
            state <= RELEASED;
          end else if (deb_cnt == DEB_MAX) begin
            state       <= PRESSED;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
            hold_cnt    <= '0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state   <= WAIT_RELEASE;
            deb_cnt <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (s) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_MAX) begin
            state         <= RELEASED;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            long_done     <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= RELEASED;
      endcase

      // Hold time keeps accumulating across rejected release bounces.
      if (holding && !releasing) begin
        if (hold_cnt == HOLD_MAX) begin
          if (!long_done) begin
            long_press_pulse <= 1'b1;
            long_done        <= 1'b1;
          end
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - Scoreboard bench for key_debouncer with small debounce/long windows.
module tb_key_debouncer;

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic [7:0] press_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
    int lvl;
  } ev_t;

  ev_t q[$];

  key_debouncer #(
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES    (32),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .btn_raw         (btn_raw),
    .btn_level       (btn_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .press_count     (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int c, input int cnt, input int lvl);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.cnt  = cnt;
    e.lvl  = lvl;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Kind codes: 1 press, 2 release, 3 long, 0 overlapping strobes.
  always @(negedge clk) begin
    int  ak;
    ev_t e;
    if (rst_n && (press_pulse || release_pulse || long_press_pulse)) begin
      ak = ( press_pulse && !release_pulse && !long_press_pulse) ? 1 :
           (!press_pulse &&  release_pulse && !long_press_pulse) ? 2 :
           (!press_pulse && !release_pulse &&  long_press_pulse) ? 3 : 0;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: kind=%0d cycle=%0d count=%0d, expected no pulse",
                 ak, cyc, press_count);
      end else begin
        e = q.pop_front();
        if (ak != e.kind || cyc != e.cyc || int'(press_count) != e.cnt || int'(btn_level) != e.lvl) begin
          fails++;
          $display("FAIL pulse_event: got kind=%0d cycle=%0d count=%0d level=%0d, expected kind=%0d cycle=%0d count=%0d level=%0d",
                   ak, cyc, press_count, btn_level, e.kind, e.cyc, e.cnt, e.lvl);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    step(3);
    chk("reset_level", btn_level, 0);
    chk("reset_press", press_pulse, 0);
    chk("reset_release", release_pulse, 0);
    chk("reset_long", long_press_pulse, 0);
    chk("reset_count", press_count, 0);
    rst_n = 1'b1;
    step(3);

    // Clean press then release
    btn_raw = 1'b0;
    push(1, cyc + 11, 1, 1);
    step(20);
    chk("clean_level_high", btn_level, 1);
    btn_raw = 1'b1;
    push(2, cyc + 11, 1, 0);
    step(20);
    chk("clean_level_low", btn_level, 0);

    // Bounce shorter than the debounce window
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      step(3);
    end
    btn_raw = 1'b1;
    step(20);
    chk("bounce_level", btn_level, 0);
    chk("bounce_count", press_count, 1);

    // Glitch during hold
    btn_raw = 1'b0;
    c = cyc;
    push(1, c + 11, 2, 1);
    push(3, c + 43, 2, 1);
    step(15);
    btn_raw = 1'b1;
    step(5);
    btn_raw = 1'b0;
    step(40);
    chk("glitch_level", btn_level, 1);
    btn_raw = 1'b1;
    push(2, cyc + 11, 2, 0);
    step(20);

    // Two long holds, one long strobe each
    for (int k = 0; k < 2; k++) begin
      btn_raw = 1'b0;
      c = cyc;
      push(1, c + 11, 3 + k, 1);
      push(3, c + 43, 3 + k, 1);
      step(100);
      btn_raw = 1'b1;
      push(2, cyc + 11, 3 + k, 0);
      step(20);
    end

    // Counter wrap from a fresh reset
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("wrap_start_count", press_count, 0);
    for (int i = 1; i <= 257; i++) begin
      btn_raw = 1'b0;
      push(1, cyc + 11, i % 256, 1);
      step(14);
      btn_raw = 1'b1;
      push(2, cyc + 11, i % 256, 0);
      step(14);
    end
    chk("wrap_count", press_count, 1);

    // Reset while pressed
    btn_raw = 1'b0;
    push(1, cyc + 11, 2, 1);
    step(15);
    chk("midpress_level", btn_level, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_level", btn_level, 0);
    chk("async_count", press_count, 0);
    chk("async_press", press_pulse, 0);
    chk("async_release", release_pulse, 0);
    chk("async_long", long_press_pulse, 0);
    step(3);
    rst_n = 1'b1;
    push(1, cyc + 11, 1, 1);
    step(20);
    chk("repress_count", press_count, 1);
    chk("repress_level", btn_level, 1);
    btn_raw = 1'b1;
    push(2, cyc + 11, 1, 0);
    step(20);

    chk("pending_events", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
